// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencer and self-checker for the load/up/hold counter.
// On start it runs a fixed programme: LOAD, count UP, HOLD, count DOWN,
// FLUSH, DONE. A reference model of the counter tracks every command
// issued. In each UP/HOLD/DOWN/FLUSH cycle, q_in is compared against that
// model. All control outputs are registers, so no input reaches an output
// through combinational logic.
module counter_seq_ctrl #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  cfg_load_val,
    input  logic [CW-1:0] cfg_up_cnt,
    input  logic [CW-1:0] cfg_hold_cnt,
    input  logic [CW-1:0] cfg_down_cnt,
    input  logic [W-1:0]  q_in,
    output logic          load,
    output logic          up,
    output logic          hold,
    output logic [W-1:0]  d,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_HOLD,
        S_DOWN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] up_len;
    logic [CW-1:0] hold_len;
    logic [CW-1:0] down_len;
    logic [CW-1:0] phase_cnt;
    logic [W-1:0]  exp_q;
    logic          start_ok;
    logic          check_en;

    // First phase after 'from' with a non-zero length, or FLUSH if none.
    function automatic state_t phase_after(input state_t        from,
                                           input logic [CW-1:0] u,
                                           input logic [CW-1:0] h,
                                           input logic [CW-1:0] dn);
        if (from == S_LOAD && u != '0)
            return S_UP;
        if ((from == S_LOAD || from == S_UP) && h != '0)
            return S_HOLD;
        if (from != S_DOWN && dn != '0)
            return S_DOWN;
        return S_FLUSH;
    endfunction

    assign start_ok = (state == S_IDLE) && start;
    assign check_en = (state == S_UP) || (state == S_HOLD) ||
                      (state == S_DOWN) || (state == S_FLUSH);

    // Next-state decode, used by the FSM register so outputs can be
    // registered in the same cycle as the state they belong to.
    always_comb begin
        // NOTE: default first so every path assigns next_state (no latch).
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  next_state = phase_after(S_LOAD, up_len, hold_len, down_len);
            S_UP,
            S_HOLD,
            S_DOWN:  if (phase_cnt == '0)
                         next_state = phase_after(state, up_len, hold_len, down_len);
            S_FLUSH: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Programme FSM: state, captured config, phase counter and the
    // registered control outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking everywhere in clocked logic so every register
            // samples pre-edge values regardless of statement order.
            state     <= S_IDLE;
            up_len    <= '0;
            hold_len  <= '0;
            down_len  <= '0;
            phase_cnt <= '0;
            load      <= 1'b0;
            up        <= 1'b1;
            hold      <= 1'b0;
            d         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= next_state;

            if (start_ok) begin
                up_len   <= cfg_up_cnt;
                hold_len <= cfg_hold_cnt;
                down_len <= cfg_down_cnt;
                d        <= cfg_load_val;
            end

            if (next_state != state) begin
                case (next_state)
                    S_UP:    phase_cnt <= up_len - 1'b1;
                    S_HOLD:  phase_cnt <= hold_len - 1'b1;
                    S_DOWN:  phase_cnt <= down_len - 1'b1;
                    default: phase_cnt <= '0;
                endcase
            end else if (phase_cnt != '0) begin
                phase_cnt <= phase_cnt - 1'b1;
            end

            load <= (next_state == S_LOAD);
            hold <= (next_state == S_HOLD) || (next_state == S_FLUSH);
            busy <= (next_state == S_LOAD) || (next_state == S_UP) ||
                    (next_state == S_HOLD) || (next_state == S_DOWN) ||
                    (next_state == S_FLUSH);
            done <= (next_state == S_DONE);
            // Direction holds its last value through HOLD and FLUSH.
            if (next_state == S_DOWN)
                up <= 1'b0;
            else if (next_state != S_HOLD && next_state != S_FLUSH)
                up <= 1'b1;
        end
    end

    // Reference counter: the same load > hold > count priority as the real one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exp_q <= '0;
        else if (load)
            exp_q <= d;
        else if (!hold)
            exp_q <= up ? exp_q + 1'b1 : exp_q - 1'b1;
    end

    // Mismatch tracking: sticky flag plus saturating count, cleared on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (start_ok) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (check_en && (q_in != exp_q)) begin
            err <= 1'b1;
            if (err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Testbench for counter_seq_ctrl. A behavioural counter closes the loop on
// q_in, and a fault switch can freeze q_in at 5. Before each programme the
// bench pushes the expected q value of every checked cycle into a queue.
// It pops those values as the DUT walks through the programme.
module tb_counter_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  cfg_load_val = '0;
    logic [CW-1:0] cfg_up_cnt   = '0;
    logic [CW-1:0] cfg_hold_cnt = '0;
    logic [CW-1:0] cfg_down_cnt = '0;
    logic [W-1:0]  q_in;
    logic          load, up, hold, busy, done, err;
    logic [W-1:0]  d;
    logic [CW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] cnt_q = '0;
    bit           stuck = 1'b0;
    logic [W-1:0] sb[$];

    counter_seq_ctrl #(.W(W), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_load_val (cfg_load_val),
        .cfg_up_cnt   (cfg_up_cnt),
        .cfg_hold_cnt (cfg_hold_cnt),
        .cfg_down_cnt (cfg_down_cnt),
        .q_in         (q_in),
        .load         (load),
        .up           (up),
        .hold         (hold),
        .d            (d),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Ideal counter driven by the DUT's commands.
    always @(posedge clk) begin
        if (load)
            cnt_q <= d;
        else if (!hold)
            cnt_q <= up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    assign q_in = stuck ? 4'd5 : cnt_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_load"},    load,    1'b0);
        check({tag, "_up"},      up,      1'b1);
        check({tag, "_hold"},    hold,    1'b0);
        check({tag, "_d"},       d,       '0);
        check({tag, "_busy"},    busy,    1'b0);
        check({tag, "_done"},    done,    1'b0);
        check({tag, "_err"},     err,     1'b0);
        check({tag, "_err_cnt"}, err_cnt, '0);
    endtask

    // One programme. fault freezes q_in at 5. poke re-asserts start (with
    // scrambled config) mid-run and again in the DONE cycle.
    task automatic run_prog(input logic [W-1:0] val, input int u, input int h,
                            input int dn, input bit fault, input bit poke);
        logic [W-1:0] m;
        logic [W-1:0] e;
        int  exp_errs;
        int  nbusy;
        bit  err_model;
        bit  seen_done;
        sb.delete();
        m = val;
        for (int i = 0; i < u; i++) begin sb.push_back(m); m = m + 1'b1; end
        for (int i = 0; i < h; i++) sb.push_back(m);
        for (int i = 0; i < dn; i++) begin sb.push_back(m); m = m - 1'b1; end
        sb.push_back(m);
        exp_errs = 0;
        if (fault)
            for (int i = 0; i < sb.size(); i++)
                if (sb[i] != 4'd5) exp_errs++;
        if (exp_errs > 255) exp_errs = 255;
        err_model = 1'b0;
        seen_done = 1'b0;

        @(negedge clk);
        stuck        = fault;
        cfg_load_val = val;
        cfg_up_cnt   = CW'(u);
        cfg_hold_cnt = CW'(h);
        cfg_down_cnt = CW'(dn);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_strobe", load, 1'b1);
        check("load_data", d, val);
        check("busy_load", busy, 1'b1);
        check("err_clear", err, 1'b0);
        check("err_cnt_clear", err_cnt, '0);
        nbusy = 1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            nbusy++;
            check("busy_run", busy, 1'b1);
            check("load_idle", load, 1'b0);
            if (sb.size() == 0) begin
                check("sb_nonempty", sb.size(), 1);
                break;
            end
            e = sb.pop_front();
            if (!fault) check("q_in", q_in, e);
            check("err_sticky", err, err_model);
            if (fault && e != 4'd5) err_model = 1'b1;
            if (poke && nbusy == 3) begin
                start        = 1'b1;
                cfg_up_cnt   = 8'd1;
                cfg_hold_cnt = 8'd0;
                cfg_down_cnt = 8'd9;
                cfg_load_val = ~val;
            end
        end

        check("done_seen", seen_done, 1'b1);
        if (seen_done) begin
            check("busy_in_done", busy, 1'b0);
            check("busy_cycles", nbusy, 2 + u + h + dn);
            check("err_final", err, err_model);
            check("err_cnt_final", err_cnt, exp_errs);
            check("sb_drained", sb.size(), 0);
            if (poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_pulse_end", done, 1'b0);
            check("idle_after_done", busy, 1'b0);
            @(negedge clk);
            check("idle_stays", busy, 1'b0);
        end
    endtask

    initial begin
        int dn_seen;
        int busy_seen;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        run_prog(4'd5, 6, 3, 4, 1'b0, 1'b0);     // basic programme
        run_prog(4'd14, 3, 0, 5, 1'b0, 1'b0);    // wrap-around, HOLD skipped
        run_prog(4'd9, 0, 0, 0, 1'b0, 1'b0);     // all counts zero
        run_prog(4'd5, 3, 0, 0, 1'b1, 1'b0);     // stuck counter, 3 errors
        run_prog(4'd5, 3, 0, 0, 1'b0, 1'b0);     // new start clears err
        run_prog(4'd5, 6, 3, 4, 1'b0, 1'b1);     // ignored starts
        run_prog(4'd5, 255, 10, 0, 1'b1, 1'b0);  // err_cnt saturation
        stuck = 1'b0;

        // Reset during UP: asynchronous return to reset values, no done.
        @(negedge clk);
        cfg_load_val = 4'd3;
        cfg_up_cnt   = 8'd8;
        cfg_hold_cnt = 8'd2;
        cfg_down_cnt = 8'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_up_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        dn_seen   = 0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dn_seen++;
            if (busy) busy_seen++;
        end
        check("no_done_after_reset", dn_seen, 0);
        check("no_busy_after_reset", busy_seen, 0);
        run_prog(4'd5, 6, 3, 4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Command sequencer and self-checker that drives the control side of the team's load/up/hold up-down counter. On a start request it issues the fixed programme: load a value, count up N cycles, hold M cycles, count down K cycles. It runs an internal reference model of the counter and compares the counter's q against the model every cycle. It sits opposite the counter and replaces hand-written stimulus in system-level runs.

Parameters:
W, 4, counter data width (bits of d/q)
CW, 8, width of the phase-length config fields and of err_cnt

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a programme; sampled only in IDLE
cfg_load_val  input  W  value driven on d during LOAD
cfg_up_cnt  input  CW  number of count-up cycles
cfg_hold_cnt  input  CW  number of hold cycles
cfg_down_cnt  input  CW  number of count-down cycles
q_in  input  W  counter output q
load  output  1  counter load strobe
up  output  1  counter direction, 1 = up
hold  output  1  counter hold
d  output  W  counter load data
busy  output  1  programme in progress
done  output  1  one-cycle pulse at end of programme
err  output  1  sticky mismatch flag
err_cnt  output  CW  mismatch count, saturating

Behaviour:
- Reset (rst_n low, async): state=IDLE; load=0, up=1, hold=0, d=0, busy=0, done=0, err=0, err_cnt=0, exp_q=0, phase counter=0.
- Counter model, identical to the DUT counter, evaluated at each rising edge: load beats hold; hold beats count; up=1 gives +1, up=0 gives -1, modulo 2^W (15+1 gives 0, 0-1 gives 15).
- All control outputs are Moore-decoded from registered state only, with no combinational path from inputs.
- Config fields are captured into internal registers on an accepted start. Config changes during a run have no effect.
- States and transitions:
  - IDLE: load=0, hold=0, up=1, busy=0. If start=1, capture config and go to LOAD.
  - LOAD, 1 cycle: load=1, d=captured value, busy=1. exp_q takes d at the closing edge. Next state is UP, or the first later phase with a non-zero count, or FLUSH if all counts are zero.
  - UP, cfg_up_cnt cycles: up=1, hold=0, load=0.
  - HOLD, cfg_hold_cnt cycles: hold=1; up keeps its last value.
  - DOWN, cfg_down_cnt cycles: up=0, hold=0.
  - FLUSH, 1 cycle: no command (hold=1). Exists only to check the last result.
  - DONE, 1 cycle: done=1, busy=0, up=1, hold=0. Next state is IDLE.
- A phase whose count is 0 is skipped entirely.
- The phase counter loads count-1 on phase entry and leaves the phase when it reaches 0.
- Checking:
  - A check is performed in every UP, HOLD, DOWN and FLUSH cycle: compare q_in against exp_q, which is the state after the previous edge.
  - No check in IDLE, LOAD or DONE.
  - On mismatch: err is set and err_cnt increments, saturating at 2^CW-1.
  - err and err_cnt are cleared only on an accepted start or on reset.
- Latency: start accepted at edge 0. LOAD occupies cycle 1. Total busy cycles = 2 + up + hold + down. done is high in the cycle after FLUSH.
- A start pulse while busy or in DONE is ignored, not queued.
- Reset mid-programme aborts immediately to the reset values. No done pulse is produced.
- The counter's own reset is not driven by this block.

Test Plan:
- W=4, load 5, up 6, hold 3, down 4, ideal counter model on q_in:
  - exp_q sequence 5,6..11, 11,11,11, 10,9,8,7.
  - busy high 15 cycles, done once, err=0, final q_in=7.
- Wrap-around: load 14, up 3, hold 0, down 5:
  - q goes 15,0,1 then 0,15,14,13,12.
  - HOLD is skipped.
  - err=0 and done after 10 busy cycles.
- All counts 0, load 9: sequence is LOAD then FLUSH then DONE; busy 2 cycles; one check, q_in=9 required.
- Fault injection, counter stuck in hold (q_in frozen at 5), load 5, up 3: err sets on the second check and err_cnt=3 at done. A new start clears both.
- start asserted on a busy cycle, and again in the DONE cycle: both ignored, and the programme length is unchanged. The next start in IDLE runs normally.
- rst_n pulled low during the UP phase: outputs go to reset values asynchronously; no done pulse; a later start runs the full programme correctly.
